mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single core-side RAM port between the instruction fetch (IF) and load/store (MEM) requesters.
//  Generates the ram_stall_valid_if / ram_stall_valid_mem requests consumed by the pipeline stall/flush controller.
//  At most one bus transaction is outstanding. MEM wins over IF by default; a starvation counter guarantees IF progress.
//  An IF fetch that is flushed is withdrawn before grant, or its response is discarded after grant.
// PARAMETERS
//  XLEN        32  address/data width
//  STARVE_MAX  4   consecutive MEM wins over a pending IF before IF is forced to win; 0 = IF always wins ties
// PORTS
//  clk                     in   1     core clock
//  rst                     in   1     asynchronous, active-low reset (0 = reset)
//  if_req_i                in   1     fetch request; held until if_rvalid_o or if_kill_i
//  if_addr_i               in   XLEN  fetch address
//  if_kill_i               in   1     flush of fetch stage; cancels pending/in-flight fetch
//  if_rdata_o              out  XLEN  fetch data, valid with if_rvalid_o
//  if_rvalid_o             out  1     1-cycle fetch completion pulse
//  mem_req_i               in   1     load/store request; held until mem_rvalid_o
//  mem_we_i                in   1     1 = store
//  mem_addr_i              in   XLEN  load/store address
//  mem_wdata_i             in   XLEN  store data
//  mem_wstrb_i             in   XLEN/8  byte strobes
//  mem_rdata_o             out  XLEN  load data, valid with mem_rvalid_o
//  mem_rvalid_o            out  1     1-cycle load/store completion pulse (stores too)
//  bus_req_o               out  1     bus address-phase request
//  bus_we_o / bus_addr_o / bus_wdata_o / bus_wstrb_o   out  1/XLEN/XLEN/XLEN/8  registered command
//  bus_gnt_i               in   1     address phase accepted
//  bus_rvalid_i            in   1     response phase, 1 cycle
//  bus_rdata_i             in   XLEN  response data
//  ram_stall_valid_if_o    out  1     if_req_i & ~if_kill_i & ~if_rvalid_o
//  ram_stall_valid_mem_o   out  1     mem_req_i & ~mem_rvalid_o
// BEHAVIOUR
//  - Reset: state=IDLE, drop=0, starve_cnt=0. All outputs 0 (stalls follow their combinational equations).
//  - FSM states: IDLE, IF_REQ, IF_RESP, MEM_REQ, MEM_RESP.
//  - IDLE arbitration:
//    - Requests are mem_req_i and (if_req_i & ~if_kill_i).
//    - IF wins if it is the only requester, or if both request and starve_cnt==STARVE_MAX.
//    - Otherwise MEM wins. The winner's command is latched into the bus_* registers; go to X_REQ.
//  - X_REQ: bus_req_o=1 and the command is held stable. On bus_gnt_i go to X_RESP.
//  - X_RESP: bus_req_o=0. On bus_rvalid_i:
//    - Pulse X_rvalid_o, with X_rdata_o=bus_rdata_i in the same cycle (combinational).
//    - Go to IDLE. Re-arbitration occurs the next cycle; there is no back-to-back issue.
//  - Minimum latency: req@0, bus_req_o@1, gnt@1, rvalid@2 gives rvalid_o@2. Stall is high @0..1 and low @2.
//  - Starvation: starve_cnt++ (saturating) when IDLE grants MEM while IF is pending.
//    Cleared when IF is granted, or when IDLE sees no live IF request.
//  - if_kill_i handling:
//    - IDLE: the IF request is ignored that cycle.
//    - IF_REQ (no gnt that cycle): withdraw, bus_req_o=0 next cycle, go to IDLE.
//    - IF_REQ with gnt in the same cycle: go to IF_RESP with drop=1.
//    - IF_RESP: set drop=1. The response is consumed, if_rvalid_o is suppressed, go to IDLE, and drop is cleared.
//  - if_kill_i has no effect on MEM states. MEM requests are never cancelled.
//  - bus_rvalid_i outside X_RESP is ignored (simulation assertion fires). bus_gnt_i outside X_REQ is ignored.
//  - Mid-operation reset returns to IDLE immediately. A late bus_rvalid_i after reset is ignored.
//  - Commands are registered, so requester inputs changing after acceptance do not affect the bus.
// STRUCTURE
//  - FSM state localparams and XLEN go in sysconfig.v (shared include). Stall-bit maps stay in the pipeline controller.
//  - One optional sub-module: arb_starve_cnt (saturating counter with clear/inc/max flag).
//    Everything else is a single FSM plus command registers.
// TESTING
//  - Lone IF fetch, addr 0x8000_0000, gnt same cycle, rdata 0x0000_0013
//    -> if_rvalid_o@2, stall_if high cycles 0-1 only.
//  - IF and MEM request together in IDLE (starve_cnt=0)
//    -> MEM store granted first (bus_we_o=1), then IF issued.
//    -> mem_rvalid_o precedes if_rvalid_o; starve_cnt=1 then 0.
//  - IF continuously pending, MEM re-requests every transaction, STARVE_MAX=4
//    -> exactly 4 MEM transactions, then IF is granted on the 5th arbitration.
//  - if_kill_i during IF_REQ with bus_gnt_i=0 -> bus_req_o drops the next cycle, no if_rvalid_o, state IDLE.
//  - if_kill_i during IF_RESP, response 3 cycles later -> bus_rvalid_i consumed, if_rvalid_o stays 0.
//    -> A pending MEM request is then granted the cycle after.
//  - rst=0 asserted in MEM_RESP, then released
//    -> outputs 0, state IDLE, a stray bus_rvalid_i produces no mem_rvalid_o.
//    -> A held mem_req_i is reissued.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the RAM port arbiter
package mem_port_arbiter_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int STARVE_MAX_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF_REQ,
    ST_IF_RESP,
    ST_MEM_REQ,
    ST_MEM_RESP
  } arb_state_e;

  // Width of a counter that must hold 0..max; never narrower than one bit.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// rtl/mem_port_arbiter_starve_cnt.sv - saturating count of MEM wins over a waiting fetch
module mem_port_arbiter_starve_cnt #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == W'(MAX));

  // Clear has priority; increment stops at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one RAM port between fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  input  logic              if_kill_i,
  output logic [XLEN-1:0]   if_rdata_o,
  output logic              if_rvalid_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  input  logic [XLEN/8-1:0] mem_wstrb_i,
  output logic [XLEN-1:0]   mem_rdata_o,
  output logic              mem_rvalid_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [XLEN-1:0]   bus_addr_o,
  output logic [XLEN-1:0]   bus_wdata_o,
  output logic [XLEN/8-1:0] bus_wstrb_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [XLEN-1:0]   bus_rdata_i,
  output logic              ram_stall_valid_if_o,
  output logic              ram_stall_valid_mem_o
);

  localparam int CW = cnt_width(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic              drop_q, drop_d;
  logic              cmd_we_q, cmd_we_d;
  logic [XLEN-1:0]   cmd_addr_q, cmd_addr_d;
  logic [XLEN-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [XLEN/8-1:0] cmd_wstrb_q, cmd_wstrb_d;

  logic if_live, if_win, starve_max, starve_clr, starve_inc;
  logic if_rvalid, mem_rvalid;

  // A killed fetch does not take part in arbitration.
  assign if_live = if_req_i & ~if_kill_i;
  assign if_win  = if_live & (~mem_req_i | starve_max);

  mem_port_arbiter_starve_cnt #(
    .MAX (STARVE_MAX),
    .W   (CW)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (starve_clr),
    .inc      (starve_inc),
    .at_max_o (starve_max)
  );

  // Next-state, command capture and completion pulses.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_wstrb_d = cmd_wstrb_q;
    starve_clr  = 1'b0;
    starve_inc  = 1'b0;
    if_rvalid   = 1'b0;
    mem_rvalid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_win) begin
          state_d     = ST_IF_REQ;
          cmd_we_d    = 1'b0;
          cmd_addr_d  = if_addr_i;
          cmd_wdata_d = '0;
          cmd_wstrb_d = '0;
          starve_clr  = 1'b1;
        end else if (mem_req_i) begin
          state_d     = ST_MEM_REQ;
          cmd_we_d    = mem_we_i;
          cmd_addr_d  = mem_addr_i;
          cmd_wdata_d = mem_wdata_i;
          cmd_wstrb_d = mem_wstrb_i;
          starve_inc  = if_live;
          starve_clr  = ~if_live;
        end else begin
          starve_clr  = 1'b1;
        end
      end
      ST_IF_REQ: begin
        // A kill racing the grant still has to swallow the response.
        if (bus_gnt_i) begin
          state_d = ST_IF_RESP;
          drop_d  = if_kill_i;
        end else if (if_kill_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_IF_RESP: begin
        if (bus_rvalid_i) begin
          if_rvalid = ~(drop_q | if_kill_i);
          state_d   = ST_IDLE;
          drop_d    = 1'b0;
        end else if (if_kill_i) begin
          drop_d    = 1'b1;
        end
      end
      ST_MEM_REQ: begin
        if (bus_gnt_i) begin
          state_d = ST_MEM_RESP;
        end
      end
      ST_MEM_RESP: begin
        if (bus_rvalid_i) begin
          mem_rvalid = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, drop flag and registered bus command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      drop_q      <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_wstrb_q <= cmd_wstrb_d;
    end
  end

  assign bus_req_o   = (state_q == ST_IF_REQ) || (state_q == ST_MEM_REQ);
  assign bus_we_o    = cmd_we_q;
  assign bus_addr_o  = cmd_addr_q;
  assign bus_wdata_o = cmd_wdata_q;
  assign bus_wstrb_o = cmd_wstrb_q;

  assign if_rvalid_o  = if_rvalid;
  assign if_rdata_o   = if_rvalid ? bus_rdata_i : '0;
  assign mem_rvalid_o = mem_rvalid;
  assign mem_rdata_o  = mem_rvalid ? bus_rdata_i : '0;

  assign ram_stall_valid_if_o  = if_req_i & ~if_kill_i & ~if_rvalid_o;
  assign ram_stall_valid_mem_o = mem_req_i & ~mem_rvalid_o;

  // A response is only legal while one is being waited for.
  rvalid_in_resp_a: assert property (@(posedge clk) disable iff (!rst)
    bus_rvalid_i |-> (state_q == ST_IF_RESP || state_q == ST_MEM_RESP))
    else $error("bus_rvalid_i outside a response phase");

endmodule
